// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StReport,
    StWaitRelease
  } state_e;

  // {row_idx, col_idx} of a key
  typedef logic [ROW_W+COL_W-1:0] key_code_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Index of the lowest set column bit; 0 when none is set.
  function automatic logic [COL_W-1:0] lowest_col(input logic [COLS-1:0] cols);
    logic [COL_W-1:0] idx;
    idx = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (cols[i]) idx = i[COL_W-1:0];
    end
    return idx;
  endfunction

  function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_W-1:0] idx);
    logic [ROWS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/col_sync.sv
// Two-flop synchronizer for the asynchronous keypad column inputs.
module col_sync
  import keypad_pkg::*;
#(
  parameter int unsigned WIDTH = COLS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Metastability stage followed by the stable stage, both cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row scanner with press/release debounce and a valid/ready key event.
// Optional release pulse output enabled by defining KEYPAD_RELEASE_EVT_EN.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SETTLE_CYC   = 4,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] col_async,
  output logic [ROWS-1:0] row,
  output key_code_t       key_code,
  output logic            key_valid,
  input  logic            key_ready
`ifdef KEYPAD_RELEASE_EVT_EN
  ,
  output logic            key_release
`endif
);

  localparam int unsigned CNT_W = $clog2(max_u(SETTLE_CYC, DEBOUNCE_CYC) + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);

  logic [COLS-1:0]  w_col;
  logic [ROW_W-1:0] w_row_inc;

  state_e           r_state;
  logic [ROW_W-1:0] r_row_idx;
  logic [COL_W-1:0] r_col_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [ROWS-1:0]  r_row;
  key_code_t        r_key_code;
  logic             r_key_valid;
`ifdef KEYPAD_RELEASE_EVT_EN
  logic             r_key_release;
`endif

  col_sync #(
    .WIDTH (COLS)
  ) u_col_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (col_async),
    .o_sync  (w_col)
  );

  assign w_row_inc = r_row_idx + ROW_W'(1);

  // Scan/debounce FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StScan;
      r_row_idx   <= '0;
      r_col_idx   <= '0;
      r_cnt       <= '0;
      r_row       <= row_onehot('0);
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
`ifdef KEYPAD_RELEASE_EVT_EN
      r_key_release <= 1'b0;
`endif
    end else begin
`ifdef KEYPAD_RELEASE_EVT_EN
      r_key_release <= 1'b0;
`endif
      unique case (r_state)
        StScan: begin
          if (r_cnt < SETTLE_LAST) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt <= '0;
            if (|w_col) begin
              r_col_idx <= lowest_col(w_col);
              r_state   <= StDebounce;
            end else begin
              r_row_idx <= w_row_inc;
              r_row     <= row_onehot(w_row_inc);
            end
          end
        end
        StDebounce: begin
          if (!w_col[r_col_idx]) begin
            // Bounce: abandon this key and keep scanning from the next row.
            r_cnt     <= '0;
            r_row_idx <= w_row_inc;
            r_row     <= row_onehot(w_row_inc);
            r_state   <= StScan;
          end else if (r_cnt >= DEB_LAST) begin
            r_cnt       <= '0;
            r_key_code  <= {r_row_idx, r_col_idx};
            r_key_valid <= 1'b1;
            r_state     <= StReport;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StReport: begin
          if (key_ready) begin
            r_key_valid <= 1'b0;
            r_state     <= StWaitRelease;
          end
        end
        StWaitRelease: begin
          if (w_col[r_col_idx]) begin
            r_cnt <= '0;
          end else if (r_cnt >= DEB_LAST) begin
            r_cnt     <= '0;
            r_row_idx <= w_row_inc;
            r_row     <= row_onehot(w_row_inc);
            r_state   <= StScan;
`ifdef KEYPAD_RELEASE_EVT_EN
            r_key_release <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= StScan;
      endcase
    end
  end

  assign row       = r_row;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
`ifdef KEYPAD_RELEASE_EVT_EN
  assign key_release = r_key_release;
`endif

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: stimulus pushes expected key codes, a monitor
// pops and compares on every valid&&ready transfer.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_async;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b1;
`ifdef KEYPAD_RELEASE_EVT_EN
  logic       key_release;
`endif

  logic [15:0] keys = '0;  // keys[r*4+c] = key at row r, column c is pressed
  logic [3:0]  exp_q[$];
  int          tests = 0;
  int          fails = 0;

  logic        m_stall = 1'b0;
  logic        m_xfer  = 1'b0;
  logic [3:0]  m_held_code = '0;
  logic [3:0]  m_exp;

  keypad_scan_ctrl #(
    .SETTLE_CYC   (4),
    .DEBOUNCE_CYC (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col_async (col_async),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready)
`ifdef KEYPAD_RELEASE_EVT_EN
    ,
    .key_release (key_release)
`endif
  );

  always #5 clk = ~clk;

  // Keypad matrix: a driven row shorts pressed keys onto their columns.
  always_comb begin
    col_async = '0;
    for (int r = 0; r < 4; r++) begin
      if (row[r]) col_async = col_async | keys[r*4 +: 4];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wait (bounded) for the first negedge of a fresh dwell on the target row.
  task automatic wait_row_start(input logic [3:0] target);
    int n = 0;
    while (row == target && n < 50) begin
      @(negedge clk);
      n++;
    end
    while (row != target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_row_reached", row, target);
  endtask

  // Monitor: scoreboard compare on transfers, hold/drop checks around them.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_stall = 1'b0;
        m_xfer  = 1'b0;
      end else begin
        if (m_stall) begin
          check("stall_valid_held", key_valid, 1);
          check("stall_code_held", key_code, m_held_code);
        end
        if (m_xfer) check("valid_low_after_xfer", key_valid, 0);
        m_xfer      = key_valid && key_ready;
        m_stall     = key_valid && !key_ready;
        m_held_code = key_code;
        if (m_xfer) begin
          check("event_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            m_exp = exp_q.pop_front();
            check("key_code", key_code, m_exp);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset and idle rotation
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_row", row, 4'b0001);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 4'h0);
    repeat (3) begin
      @(negedge clk);
      check("settle_row0", row, 4'b0001);
    end
    @(negedge clk);
    check("rotate_row1", row, 4'b0010);

    // Held press row2/col1 -> exactly one event 4'h9
    exp_q.push_back(4'h9);
    keys[2*4+1] = 1'b1;
    repeat (200) @(negedge clk);
    check("press_event_seen", exp_q.size(), 0);
    keys = '0;
`ifdef KEYPAD_RELEASE_EVT_EN
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!key_release && n < 60);
    check("release_delay", n, 18);
    check("release_code", key_code, 4'h9);
    @(negedge clk);
    check("release_one_cycle", key_release, 0);
    repeat (20) @(negedge clk);
`else
    repeat (40) @(negedge clk);
`endif

    // Bounce row1/col2 for 5 cycles -> no event, scan resumes at row2
    wait_row_start(4'b0010);
    keys[1*4+2] = 1'b1;
    repeat (5) @(negedge clk);
    check("bounce_row_held", row, 4'b0010);
    keys = '0;
    repeat (2) @(negedge clk);
    check("bounce_still_debouncing", row, 4'b0010);
    @(negedge clk);
    check("bounce_resume_row2", row, 4'b0100);
    repeat (10) @(negedge clk);

    // Backpressure: row3/col0 -> 4'hC held while key_ready=0
    @(posedge clk);
    #1 key_ready = 1'b0;
    exp_q.push_back(4'hC);
    keys[3*4+0] = 1'b1;
    n = 0;
    while (!key_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", key_valid, 1);
    repeat (50) @(negedge clk);
    check("bp_valid_held", key_valid, 1);
    check("bp_code_held", key_code, 4'hC);
    @(posedge clk);
    #1 key_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("bp_valid_dropped", key_valid, 0);
    check("bp_event_seen", exp_q.size(), 0);
    keys = '0;
    repeat (40) @(negedge clk);

    // Simultaneous row0 col0+col3 -> lowest column only
    exp_q.push_back(4'h0);
    keys[0] = 1'b1;
    keys[3] = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("simul_event_seen", exp_q.size(), 0);
    keys = '0;
    repeat (40) @(negedge clk);

    // Reset mid-debounce on row1/col1 -> no event
    wait_row_start(4'b0010);
    keys[1*4+1] = 1'b1;
    repeat (8) @(negedge clk);
    check("mid_debounce_row_held", row, 4'b0010);
    rst  = 1'b1;
    keys = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst2_row", row, 4'b0001);
    check("rst2_valid", key_valid, 0);
    check("rst2_code", key_code, 4'h0);
    repeat (100) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
